ddr_host_req_arbiter: RTL and testbench

- Parametrised host-side front end for the DDR4 controller. It replaces the single request/phy_addr/wr_data host port with N_CH independent host channels.
- Each channel has its own request FIFO. A round-robin arbiter issues into one controller command port.
- Returned read data is routed back to the issuing channel through an in-order tag FIFO.
- MRS reconfiguration (CL/AL/BL/CWL/RD_PRE/WR_PRE) is sequenced safely: drain, one-cycle mrs_update pulse, then a tMOD hold-off.

---
 rtl/ddr_pkg.sv | 33 +++
 rtl/ddr_sync_fifo.sv | 57 +++++
 rtl/ddr_host_req_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_ddr_host_req_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
//------------------------------------------------------------------------------
// Module  : ddr_pkg
// Purpose : Shared types for the DDR host request arbiter: the MRS
//           configuration record and the arbiter sequencing states.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ddr_pkg;

  // Mode-register fields that are reprogrammed as one atomic group
  typedef struct packed {
    logic [2:0] cl;
    logic [1:0] al;
    logic [2:0] bl;
    logic [2:0] cwl;
    logic       rd_pre;
    logic       wr_pre;
  } req_cfg_t;

  localparam int CFG_W = $bits(req_cfg_t);

  // Issue sequencing around a mode-register update
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    MRS   = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ddr_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : ddr_sync_fifo
// Purpose : Single-clock FIFO with show-ahead output. Pointers carry an extra
//           wrap bit so full and empty fall out of pointer comparison.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; a full FIFO refuses pushes even if popped the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/ddr_host_req_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ddr_host_req_arbiter
// Purpose : N_CH host request channels, round-robin issue into one controller
//           command port, in-order read return routing and safe MRS sequencing.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr_host_req_arbiter
  import ddr_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RD_OUT = 16,
  parameter int T_MOD  = 24,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CK_t,
  input  logic                     reset,
  input  logic [N_CH-1:0]          host_valid,
  output logic [N_CH-1:0]          host_ready,
  input  logic [N_CH-1:0]          host_wr,
  input  logic [N_CH*ADDR_W-1:0]   host_addr,
  input  logic [N_CH*DATA_W-1:0]   host_wdata,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [2:0]               cfg_cl,
  input  logic [1:0]               cfg_al,
  input  logic [2:0]               cfg_bl,
  input  logic [2:0]               cfg_cwl,
  input  logic                     cfg_rd_pre,
  input  logic                     cfg_wr_pre,
  output logic                     ctrl_valid,
  input  logic                     ctrl_ready,
  output logic                     ctrl_wr,
  output logic [ADDR_W-1:0]        ctrl_addr,
  output logic [DATA_W-1:0]        ctrl_wdata,
  output logic [CH_W-1:0]          ctrl_ch,
  output logic [2:0]               CL,
  output logic [1:0]               AL,
  output logic [2:0]               BL,
  output logic [2:0]               CWL,
  output logic                     RD_PRE,
  output logic                     WR_PRE,
  output logic                     mrs_update,
  input  logic                     rd_valid,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [N_CH-1:0]          host_rvalid,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     busy,
  output logic                     err_rd_orphan
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;
  localparam int QAW   = $clog2(DEPTH);
  localparam int TAW   = $clog2(RD_OUT);
  localparam int MW    = $clog2(T_MOD);

  logic [N_CH-1:0]  req_full, req_empty, req_push, req_pop, elig, ch_busy;
  logic [REQ_W-1:0] req_head [N_CH];
  logic [QAW:0]     req_count [N_CH];
  logic [REQ_W-1:0] head_sel;

  logic             tag_full, tag_empty, tag_push, tag_pop;
  logic [CH_W-1:0]  tag_head;
  logic [TAW:0]     tag_count;

  logic [CH_W-1:0]  rr_ptr, grant, cand;
  logic             grant_any, issue_en, load;
  int               idx;

  arb_state_t       state, state_next;
  req_cfg_t         cfg_pend, cfg_act;
  logic [MW-1:0]    mod_cnt;

  assign host_ready = ~req_full;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign req_push[i] = host_valid[i] & ~req_full[i];
    assign req_pop[i]  = load & (grant == CH_W'(i));
    assign elig[i]     = ~req_empty[i] & (req_head[i][REQ_W-1] | ~tag_full);
    assign ch_busy[i]  = (req_count[i] != '0);

    ddr_sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_req_fifo (
      .clk   (CK_t),
      .reset (reset),
      .push  (req_push[i]),
      .din   ({host_wr[i], host_addr[i*ADDR_W +: ADDR_W], host_wdata[i*DATA_W +: DATA_W]}),
      .pop   (req_pop[i]),
      .dout  (req_head[i]),
      .full  (req_full[i]),
      .empty (req_empty[i]),
      .count (req_count[i])
    );
  end

  // Round-robin pick: first eligible channel at or after rr_ptr wins
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = CH_W'(idx);
      if (elig[cand]) begin
        grant     = cand;
        grant_any = 1'b1;
      end
    end
  end

  assign head_sel = req_head[grant];
  assign load     = (~ctrl_valid | ctrl_ready) & issue_en & grant_any;

  // rr_ptr holds the channel with top priority next; it moves only on a grant
  always_ff @(posedge CK_t) begin
    if (reset)     rr_ptr <= '0;
    else if (load) rr_ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
  end

  // Command output register; holds steady while the controller stalls
  always_ff @(posedge CK_t) begin
    if (reset) begin
      ctrl_valid <= 1'b0;
      ctrl_wr    <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      ctrl_ch    <= '0;
    end else if (load) begin
      ctrl_valid                       <= 1'b1;
      {ctrl_wr, ctrl_addr, ctrl_wdata} <= head_sel;
      ctrl_ch                          <= grant;
    end else if (ctrl_ready) begin
      ctrl_valid <= 1'b0;
    end
  end

  assign tag_push = load & ~head_sel[REQ_W-1];
  assign tag_pop  = rd_valid & ~tag_empty;

  ddr_sync_fifo #(.WIDTH(CH_W), .DEPTH(RD_OUT)) u_tag_fifo (
    .clk   (CK_t),
    .reset (reset),
    .push  (tag_push),
    .din   (grant),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Read return steered to the oldest outstanding tag in the same cycle
  always_comb begin
    host_rvalid = '0;
    host_rdata  = '0;
    if (tag_pop) begin
      host_rvalid[tag_head] = 1'b1;
      host_rdata            = rd_data;
    end
  end

  // Sticky flag for read data that had no issuing channel to return to
  always_ff @(posedge CK_t) begin
    if (reset)                        err_rd_orphan <= 1'b0;
    else if (rd_valid && tag_empty)   err_rd_orphan <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge CK_t) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // FSM next-state: drain commands and reads before reprogramming, then hold off
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (cfg_valid)                    state_next = DRAIN;
      DRAIN:   if (!ctrl_valid && tag_empty)     state_next = MRS;
      MRS:                                       state_next = WAIT;
      WAIT:    if (mod_cnt == '0)                state_next = RUN;
      default:                                   state_next = RUN;
    endcase
  end

  // FSM outputs; the last WAIT cycle may already load so the first command
  // appears exactly T_MOD cycles after the mrs_update pulse
  always_comb begin
    cfg_ready  = (state == RUN);
    mrs_update = (state == MRS);
    issue_en   = (state == RUN) || ((state == WAIT) && (mod_cnt == '0));
  end

  // Pending/active configuration and the tMOD hold-off counter
  always_ff @(posedge CK_t) begin
    if (reset) begin
      cfg_pend <= '0;
      cfg_act  <= '0;
      mod_cnt  <= '0;
    end else begin
      if (state == RUN && cfg_valid) begin
        cfg_pend.cl     <= cfg_cl;
        cfg_pend.al     <= cfg_al;
        cfg_pend.bl     <= cfg_bl;
        cfg_pend.cwl    <= cfg_cwl;
        cfg_pend.rd_pre <= cfg_rd_pre;
        cfg_pend.wr_pre <= cfg_wr_pre;
      end
      if (state_next == MRS && state != MRS) begin
        cfg_act <= cfg_pend;
        mod_cnt <= MW'(T_MOD - 1);
      end else if (mod_cnt != '0) begin
        mod_cnt <= mod_cnt - MW'(1);
      end
    end
  end

  assign CL     = cfg_act.cl;
  assign AL     = cfg_act.al;
  assign BL     = cfg_act.bl;
  assign CWL    = cfg_act.cwl;
  assign RD_PRE = cfg_act.rd_pre;
  assign WR_PRE = cfg_act.wr_pre;

  assign busy = (|ch_busy) | (tag_count != '0) | ctrl_valid | (state != RUN);

endmodule

`default_nettype wire

// File: tb/tb_ddr_host_req_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ddr_host_req_arbiter
// Purpose : Scoreboard bench for ddr_host_req_arbiter (default parameters).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr_host_req_arbiter;

  localparam int N_CH = 4, AW = 32, DW = 64, T_MOD = 24;

  typedef struct {
    int          ch;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
  } cmd_t;

  logic CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  logic              reset;
  logic [N_CH-1:0]   host_valid, host_ready, host_wr, host_rvalid;
  logic [N_CH*AW-1:0] host_addr;
  logic [N_CH*DW-1:0] host_wdata;
  logic              cfg_valid, cfg_ready, cfg_rd_pre, cfg_wr_pre;
  logic [2:0]        cfg_cl, cfg_bl, cfg_cwl;
  logic [1:0]        cfg_al;
  logic              ctrl_valid, ctrl_ready, ctrl_wr;
  logic [AW-1:0]     ctrl_addr;
  logic [DW-1:0]     ctrl_wdata;
  logic [1:0]        ctrl_ch;
  logic [2:0]        CL, BL, CWL;
  logic [1:0]        AL;
  logic              RD_PRE, WR_PRE, mrs_update;
  logic              rd_valid;
  logic [DW-1:0]     rd_data, host_rdata;
  logic              busy, err_rd_orphan;

  ddr_host_req_arbiter dut (
    .CK_t(CK_t), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_wr(host_wr),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cl(cfg_cl), .cfg_al(cfg_al),
    .cfg_bl(cfg_bl), .cfg_cwl(cfg_cwl), .cfg_rd_pre(cfg_rd_pre), .cfg_wr_pre(cfg_wr_pre),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_wr(ctrl_wr),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_ch(ctrl_ch),
    .CL(CL), .AL(AL), .BL(BL), .CWL(CWL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE),
    .mrs_update(mrs_update), .rd_valid(rd_valid), .rd_data(rd_data),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .busy(busy), .err_rd_orphan(err_rd_orphan)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  cmd_t exp_q[$];
  int   rd_q[$];
  cmd_t mon_e;
  int   mon_c;
  cmd_t held;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] addr, input logic [63:0] data);
    host_wr[ch]             = wr;
    host_addr[ch*AW +: AW]  = addr;
    host_wdata[ch*DW +: DW] = data;
  endtask

  task automatic push_exp(input int ch, input logic wr, input logic [31:0] addr, input logic [63:0] data);
    cmd_t c;
    c.ch = ch; c.wr = wr; c.addr = addr; c.data = data;
    exp_q.push_back(c);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_host_ready"}, host_ready, 4'hF);
    check({pfx, "_cfg_ready"}, cfg_ready, 1);
    check({pfx, "_ctrl_valid"}, ctrl_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_err"}, err_rd_orphan, 0);
    check({pfx, "_cfg"}, {CL, AL, BL, CWL, RD_PRE, WR_PRE, mrs_update}, 0);
    check({pfx, "_rvalid"}, host_rvalid, 0);
  endtask

  task automatic do_reset();
    reset = 1; host_valid = '0; rd_valid = 0; cfg_valid = 0; ctrl_ready = 0;
    tick(); tick();
    exp_q.delete(); rd_q.delete();
    check_reset_vals("rst");
    reset = 0;
  endtask

  task automatic wait_exp_empty(input string tag, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: accepted commands against predicted order, returns against tags
  always @(negedge CK_t) begin
    if (!reset) begin
      if (ctrl_valid && ctrl_ready) begin
        if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("cmd_ch", ctrl_ch, mon_e.ch);
          check("cmd_wr", ctrl_wr, mon_e.wr);
          check("cmd_addr", ctrl_addr, mon_e.addr);
          if (mon_e.wr) check("cmd_data", ctrl_wdata, mon_e.data);
          else rd_q.push_back(mon_e.ch);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("orphan_rvalid", host_rvalid, 0);
        else begin
          mon_c = rd_q.pop_front();
          check("rd_onehot", host_rvalid, 1 << mon_c);
          check("rd_data", host_rdata, rd_data);
        end
      end else begin
        check("rvalid_idle", host_rvalid, 0);
      end
    end
  end

  initial begin
    int cnt;
    bit seen;
    reset = 1; host_valid = '0; host_wr = '0; host_addr = '0; host_wdata = '0;
    cfg_valid = 0; cfg_cl = 0; cfg_al = 0; cfg_bl = 0; cfg_cwl = 0;
    cfg_rd_pre = 0; cfg_wr_pre = 0; ctrl_ready = 0; rd_valid = 0; rd_data = '0;

    // Single write on channel 0
    do_reset();
    ctrl_ready = 1;
    set_req(0, 1, 32'h100, 64'hAA); push_exp(0, 1, 32'h100, 64'hAA);
    host_valid = 4'b0001;
    tick();
    host_valid = '0;
    check("t1_latency", ctrl_valid, 0);
    tick();
    check("t1_valid", ctrl_valid, 1);
    check("t1_ch", ctrl_ch, 0);
    tick(); tick();
    check("t1_idle", busy, 0);

    // Round robin over four channels, two reads each
    do_reset();
    ctrl_ready = 1;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        set_req(c, 0, 32'h200 + c * 16 + n, 64'h0);
        push_exp(c, 0, 32'h200 + c * 16 + n, 64'h0);
      end
      host_valid = 4'hF;
      tick();
    end
    host_valid = '0;
    for (int k = 0; k < 8; k++) begin
      check("t2_nobubble", ctrl_valid, 1);
      tick();
    end
    check("t2_done", ctrl_valid, 0);
    for (int k = 0; k < 8; k++) begin
      rd_valid = 1; rd_data = 64'hD0 + k;
      tick();
    end
    rd_valid = 0;
    check("t2_rd_left", rd_q.size(), 0);
    check("t2_busy", busy, 0);

    // Backpressure with channel 1 overfilled
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_req(1, 1, 32'h300 + k, 64'hB00 + k);
      host_valid = 4'b0010;
      check("t3_ready", host_ready[1], (k < 9));
      if (k < 9) push_exp(1, 1, 32'h300 + k, 64'hB00 + k);
      tick();
      if (k >= 1) begin
        check("t3_hold_valid", ctrl_valid, 1);
        check("t3_hold_addr", ctrl_addr, 32'h300);
        check("t3_hold_data", ctrl_wdata, 64'hB00);
      end
    end
    host_valid = '0;
    ctrl_ready = 1;
    wait_exp_empty("t3_drain", 40);
    tick();
    check("t3_busy", busy, 0);

    // Tag FIFO full: 17th read held, write on another channel passes
    do_reset();
    ctrl_ready = 1;
    for (int k = 0; k < 17; k++) begin
      set_req(0, 0, 32'h400 + k, 64'h0);
      if (k < 16) push_exp(0, 0, 32'h400 + k, 64'h0);
      else begin held.ch = 0; held.wr = 0; held.addr = 32'h400 + k; held.data = 0; end
      host_valid = 4'b0001;
      tick();
    end
    set_req(1, 1, 32'h500, 64'h55);
    push_exp(1, 1, 32'h500, 64'h55);
    exp_q.push_back(held);
    host_valid = 4'b0010;
    tick();
    host_valid = '0;
    repeat (4) tick();
    check("t4_held", exp_q.size(), 1);
    check("t4_idle", ctrl_valid, 0);
    rd_valid = 1; rd_data = 64'hE0;
    tick();
    rd_valid = 0;
    wait_exp_empty("t4_release", 10);
    for (int i = 0; i < 20 && rd_q.size() != 0; i++) begin
      rd_valid = 1; rd_data = 64'hE1 + i;
      tick();
    end
    rd_valid = 0;
    check("t4_rd_left", rd_q.size(), 0);

    // MRS sequencing with two reads outstanding
    do_reset();
    ctrl_ready = 1;
    for (int k = 0; k < 2; k++) begin
      set_req(0, 0, 32'h600 + k, 64'h0);
      push_exp(0, 0, 32'h600 + k, 64'h0);
      host_valid = 4'b0001;
      tick();
    end
    host_valid = '0;
    tick(); tick();
    cfg_cl = 3'd5; cfg_al = 2'd2; cfg_bl = 3'd3; cfg_cwl = 3'd4; cfg_rd_pre = 1; cfg_wr_pre = 0;
    cfg_valid = 1;
    set_req(1, 1, 32'h700, 64'h77);
    push_exp(1, 1, 32'h700, 64'h77);
    host_valid = 4'b0010;
    tick();
    cfg_valid = 0; host_valid = '0;
    check("t5_cfg_ready", cfg_ready, 0);
    for (int k = 0; k < 5; k++) begin
      check("t5_drain_hold", ctrl_valid, 0);
      check("t5_no_mrs", mrs_update, 0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      rd_valid = 1; rd_data = 64'hC0 + k;
      tick();
    end
    rd_valid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mrs_update) seen = 1;
      else tick();
    end
    check("t5_mrs_seen", seen, 1);
    check("t5_cl", CL, 5);
    check("t5_al_rdpre", {AL, RD_PRE}, {2'd2, 1'b1});
    tick();
    check("t5_pulse_width", mrs_update, 0);
    cnt = 1;
    while (!ctrl_valid && cnt < T_MOD + 10) begin
      tick();
      cnt++;
    end
    check("t5_tmod", cnt, T_MOD);
    wait_exp_empty("t5_write", 5);

    // Orphan read return, then reset during activity
    tick();
    rd_valid = 1; rd_data = 64'hF0;
    tick();
    rd_valid = 0;
    check("t6_orphan", err_rd_orphan, 1);
    repeat (3) tick();
    check("t6_sticky", err_rd_orphan, 1);
    ctrl_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_req(2, 1, 32'h800 + k, 64'h0);
      set_req(3, 0, 32'h900 + k, 64'h0);
      host_valid = 4'b1100;
      tick();
    end
    check("t6_busy_pre", busy, 1);
    reset = 1; host_valid = '0;
    tick();
    exp_q.delete(); rd_q.delete();
    check_reset_vals("t6_midrst");
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
